// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  localparam int unsigned TEXT_BITS = 16;

  localparam logic [31:0] FETCH_STEP = 32'd4;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small pointer/count FIFO with synchronous write, fall-through head read and flush.
module fetch_fifo #(
  parameter int unsigned DEPTH   = 4,
  parameter type         entry_t = logic [63:0]
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  output entry_t                   head,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  entry_t           mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;

  // Storage is cleared on reset so an empty head reads as all zeros.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
      mem    <= '{default: '0};
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch_buffer.sv
// Fetch stage: sequential PC drives text memory, words are queued as {pc, inst}
// and handed to decode over valid/ready; a redirect reloads the PC and flushes.
module instruction_fetch_buffer
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0040_0000
) (
  input  logic                 clock,
  input  logic                 reset,
  output logic [TEXT_BITS-3:0] text_address,
  input  logic [31:0]          text_q,
  input  logic                 redirect_valid,
  input  logic [31:0]          redirect_pc,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [31:0]          out_pc,
  output logic [31:0]          out_inst
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic [31:0]      fetch_pc;
  logic [31:0]      redirect_target;
  logic [CNT_W-1:0] count;
  logic             full;
  logic             enq;
  logic             deq;
  fetch_entry_t     push_data;
  fetch_entry_t     head;

  assign redirect_target = redirect_pc & ~32'h3;

  // Redirect masks the head and blocks both FIFO ports for its cycle.
  assign full      = (count == CNT_W'(DEPTH));
  assign out_valid = (count != '0) & ~redirect_valid;
  assign deq       = out_valid & out_ready;
  assign enq       = ~redirect_valid & (~full | deq);

  assign push_data.pc   = fetch_pc;
  assign push_data.inst = text_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc <= redirect_target;
    end else if (enq) begin
      fetch_pc <= fetch_pc + FETCH_STEP;
    end
  end

  assign text_address = fetch_pc[TEXT_BITS-1:2];

  fetch_fifo #(
    .DEPTH   (DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clock     (clock),
    .reset     (reset),
    .flush     (redirect_valid),
    .push      (enq),
    .push_data (push_data),
    .pop       (deq),
    .head      (head),
    .count     (count)
  );

  assign out_pc   = head.pc;
  assign out_inst = head.inst;

endmodule

// File: tb/tb_instruction_fetch_buffer.sv
// Self-checking bench for instruction_fetch_buffer with a PC-stream scoreboard.
module tb_instruction_fetch_buffer;
  import fetch_pkg::*;

  localparam logic [31:0] RESET_PC = 32'h0040_0000;
  localparam int unsigned AW       = TEXT_BITS - 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [AW-1:0] text_address;
  logic [31:0]   text_q;
  logic          redirect_valid;
  logic [31:0]   redirect_pc;
  logic          out_valid;
  logic          out_ready;
  logic [31:0]   out_pc;
  logic [31:0]   out_inst;

  int          checks   = 0;
  int          failures = 0;
  logic [31:0] sb [$];

  always #5 clock = ~clock;

  function automatic logic [31:0] f(input logic [AW-1:0] a);
    return 32'hA500_0003 | (32'(a) << 4);
  endfunction

  function automatic logic [AW-1:0] addr_of(input logic [31:0] pc);
    return pc[TEXT_BITS-1:2];
  endfunction

  assign text_q = f(text_address);

  instruction_fetch_buffer #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
    .clock          (clock),
    .reset          (reset),
    .text_address   (text_address),
    .text_q         (text_q),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_pc         (out_pc),
    .out_inst       (out_inst)
  );

  // Expected fetch stream from a new start PC.
  task automatic sb_restart(input logic [31:0] start);
    sb.delete();
    for (int i = 0; i < 64; i++) sb.push_back(start + 32'(4 * i));
  endtask

  task automatic next_cycle();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    #1;
    checks += 4;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid: got %b want 0", out_valid); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL reset_pc: got %h want 0", out_pc); end
    if (out_inst !== 32'h0) begin failures++; $display("FAIL reset_inst: got %h want 0", out_inst); end
    if (text_address !== addr_of(RESET_PC)) begin
      failures++; $display("FAIL reset_addr: got %h want %h", text_address, addr_of(RESET_PC));
    end
    reset = 1'b0;
    sb_restart(RESET_PC);
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL release_valid: got %b want 0", out_valid); end
    next_cycle();
  endtask

  task automatic test_stall();
    out_ready = 1'b0;
    for (int k = 0; k < 10; k++) begin
      #1;
      checks += 2;
      if (out_valid !== 1'b1) begin failures++; $display("FAIL stall_valid[%0d]: got %b want 1", k, out_valid); end
      if (out_pc !== RESET_PC) begin failures++; $display("FAIL stall_pc[%0d]: got %h want %h", k, out_pc, RESET_PC); end
      if (k >= 3) begin
        checks++;
        if (text_address !== addr_of(RESET_PC + 32'd16)) begin
          failures++; $display("FAIL stall_addr[%0d]: got %h want %h", k, text_address, addr_of(RESET_PC + 32'd16));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_full_swap();
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    #1;
    checks++;
    if (!(out_valid && out_ready) || sb.size() == 0) begin
      failures++; $display("FAIL swap_deq: valid=%b want 1", out_valid);
    end else begin
      exp_pc = sb.pop_front();
      if (out_pc !== exp_pc || out_inst !== f(addr_of(exp_pc))) begin
        failures++; $display("FAIL swap_pop: got %h/%h want %h/%h", out_pc, out_inst, exp_pc, f(addr_of(exp_pc)));
      end
    end
    next_cycle();
    out_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      checks += 2;
      if (out_pc !== RESET_PC + 32'd4) begin
        failures++; $display("FAIL swap_head[%0d]: got %h want %h", k, out_pc, RESET_PC + 32'd4);
      end
      if (text_address !== addr_of(RESET_PC + 32'd20)) begin
        failures++; $display("FAIL swap_addr[%0d]: got %h want %h", k, text_address, addr_of(RESET_PC + 32'd20));
      end
      next_cycle();
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    for (int k = 0; k < 8; k++) begin
      #1;
      checks++;
      if (!(out_valid && out_ready) || sb.size() == 0) begin
        failures++; $display("FAIL stream_valid[%0d]: got %b want 1", k, out_valid);
      end else begin
        exp_pc = sb.pop_front();
        if (out_pc !== exp_pc || out_inst !== f(addr_of(exp_pc))) begin
          failures++; $display("FAIL stream_pop[%0d]: got %h/%h want %h/%h", k, out_pc, out_inst, exp_pc, f(addr_of(exp_pc)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_redirect();
    logic [31:0] exp_pc;
    out_ready      = 1'b0;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0080;
    sb_restart(32'h0040_0080);
    next_cycle();
    redirect_valid = 1'b0;
    for (int k = 0; k < 3; k++) next_cycle();
    #1;
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 32'h0040_0080) begin
      failures++; $display("FAIL redir_setup: got %b/%h want 1/00400080", out_valid, out_pc);
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0103;
    out_ready      = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_mask: got %b want 0", out_valid); end
    sb_restart(32'h0040_0100);
    next_cycle();
    redirect_valid = 1'b0;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_r1_valid: got %b want 0", out_valid); end
    if (text_address !== addr_of(32'h0040_0100)) begin
      failures++; $display("FAIL redir_r1_addr: got %h want %h", text_address, addr_of(32'h0040_0100));
    end
    next_cycle();
    for (int k = 0; k < 3; k++) begin
      #1;
      checks++;
      if (!(out_valid && out_ready) || sb.size() == 0) begin
        failures++; $display("FAIL redir_valid[%0d]: got %b want 1", k, out_valid);
      end else begin
        exp_pc = sb.pop_front();
        if (out_pc !== exp_pc || out_inst !== f(addr_of(exp_pc))) begin
          failures++; $display("FAIL redir_pop[%0d]: got %h/%h want %h/%h", k, out_pc, out_inst, exp_pc, f(addr_of(exp_pc)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] exp_pc;
    out_ready      = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0040_0200;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_mask0: got %b want 0", out_valid); end
    next_cycle();
    redirect_pc = 32'h0040_0300;
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_mask1: got %b want 0", out_valid); end
    if (text_address !== addr_of(32'h0040_0200)) begin
      failures++; $display("FAIL b2b_addr0: got %h want %h", text_address, addr_of(32'h0040_0200));
    end
    next_cycle();
    redirect_valid = 1'b0;
    sb_restart(32'h0040_0300);
    #1;
    checks += 2;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL b2b_r1_valid: got %b want 0", out_valid); end
    if (text_address !== addr_of(32'h0040_0300)) begin
      failures++; $display("FAIL b2b_addr1: got %h want %h", text_address, addr_of(32'h0040_0300));
    end
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (!(out_valid && out_ready) || sb.size() == 0) begin
        failures++; $display("FAIL b2b_valid[%0d]: got %b want 1", k, out_valid);
      end else begin
        exp_pc = sb.pop_front();
        if (out_pc !== exp_pc || out_inst !== f(addr_of(exp_pc))) begin
          failures++; $display("FAIL b2b_pop[%0d]: got %h/%h want %h/%h", k, out_pc, out_inst, exp_pc, f(addr_of(exp_pc)));
        end
      end
      next_cycle();
    end
  endtask

  task automatic test_async_reset();
    logic [31:0] exp_pc;
    out_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks += 3;
    if (out_valid !== 1'b0) begin failures++; $display("FAIL areset_valid: got %b want 0", out_valid); end
    if (out_pc !== 32'h0) begin failures++; $display("FAIL areset_pc: got %h want 0", out_pc); end
    if (text_address !== addr_of(RESET_PC)) begin
      failures++; $display("FAIL areset_addr: got %h want %h", text_address, addr_of(RESET_PC));
    end
    #1;
    reset = 1'b0;
    sb_restart(RESET_PC);
    next_cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      checks++;
      if (!(out_valid && out_ready) || sb.size() == 0) begin
        failures++; $display("FAIL areset_restart_valid[%0d]: got %b want 1", k, out_valid);
      end else begin
        exp_pc = sb.pop_front();
        if (out_pc !== exp_pc || out_inst !== f(addr_of(exp_pc))) begin
          failures++; $display("FAIL areset_pop[%0d]: got %h/%h want %h/%h", k, out_pc, out_inst, exp_pc, f(addr_of(exp_pc)));
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    reset          = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    out_ready      = 1'b0;
    @(negedge clock);
    test_reset();
    test_stall();
    test_full_swap();
    test_stream();
    test_redirect();
    test_back_to_back();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

endmodule
